sma_multichannel: RTL and testbench
===================================

# sma_multichannel

Parametrised multi-channel simple-moving-average engine for the series preprocessing path. It accepts time-multiplexed samples tagged with a channel number and keeps an independent circular window, running sum, write index and fill count per channel. It emits one rounded average per accepted sample, one cycle later. It is the generalised successor of the single-channel SMA stage, adding configurable width, depth and channel count, round-to-nearest, per-channel clear, a window-full flag and async reset.

## Interface
- DATA_W, 16: sample/result width, unsigned (Q8.8 at default)
- N, 8: window depth per channel; power of 2, ≥2
- CH, 4: number of channels; ≥1
- CH_W, $clog2(CH) (min 1): channel-tag width, derived
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample strobe; one sample per cycle max
- in_ch  in  CH_W  channel of the sample
- in_data  in  DATA_W  sample value
- clr  in  1  clear-channel strobe
- clr_ch  in  CH_W  channel to clear
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CH_W  channel of the result
- out_data  out  DATA_W  rounded average
- out_full  out  1  window for out_ch held N real samples when the result was computed

## Operation
- Per-channel state: window[N] of DATA_W, sum of DATA_W+$clog2(N) bits, idx of $clog2(N) bits, cnt saturating at N.
- Accepted sample (in_valid and in_ch < CH), channel c:
  - new_sum = sum[c] − window[c][idx[c]] + in_data, exact with no overflow in the sum width.
  - window[c][idx[c]] ← in_data; idx[c] ← idx[c]+1, wrapping N−1→0; cnt[c] ← min(cnt[c]+1, N).
  - Result = (new_sum + N/2) >> $clog2(N), i.e. round half up. It always fits DATA_W.
- Warm-up: unwritten slots hold 0, so results before the window fills are zero-padded averages with out_full=0. out_full=1 once cnt reaches N, including the Nth sample.
- in_ch ≥ CH: sample dropped, no state change, no out_valid.
- clr with clr_ch < CH: that channel's window, sum, idx and cnt all go to 0. No output is produced. clr_ch ≥ CH is ignored.
- clr and in_valid on the same channel in the same cycle: clear is applied first, then the sample is accepted as the first entry of an empty window. window[0]=in_data, idx=1, cnt=1, result=(in_data+N/2)>>log2N, out_full=0.
- clr and in_valid on different channels in the same cycle: both take effect independently.
- Back-to-back samples on the same channel are legal every cycle. Each sample sees the state left by the previous one, with no hazard or stall.

## Timing
- Latency 1: a sample accepted on edge k produces out_valid=1 during cycle k+1 with out_ch, out_data and out_full. The result pulse lasts exactly one cycle unless another sample is accepted.
- Throughput: 1 sample/clk, no backpressure.
- rst asserted: out_valid, out_ch, out_data and out_full are 0 immediately. All windows, sums, idx and cnt are 0.
- Inputs are ignored while rst is high. The first sample is accepted on the first edge with rst low.
- Reset mid-operation discards all history and any pending output. The next sample behaves as the first after power-up.
- out_data, out_ch and out_full hold their last value while out_valid=0.

## Test plan
Defaults for all scenarios: DATA_W=16, N=4, CH=2.
- Fill: after reset, ch0 samples 0x0100 ×4 back-to-back → out_data 0x0040, 0x0080, 0x00C0, 0x0100; out_full 0,0,0,1; each result one cycle after its input.
- Wrap: then ch0 0x0200 ×4 → 0x0140, 0x0180, 0x01C0, 0x0200; all with out_full=1 (idx wrapped 3→0).
- Interleave: ch0=0x0400 and ch1=0x0010 alternating every cycle, 4 each → ch0 results 0x0100…0x0400, ch1 results 0x0004…0x0010; out_ch alternates; no cross-talk.
- Rounding and extremes:
  - ch0 samples 1, 1 → 0x0000 then 0x0001 (3>>2=0, 4>>2=1).
  - Four samples of 0xFFFF → final 0xFFFF with no overflow.
- Clear and collision:
  - Fill ch1, then clr ch1 alone → no output; the next ch1 sample 0x0008 → 0x0002, out_full=0.
  - clr ch0 with in_valid ch0=0x0100 in the same cycle → 0x0040, out_full=0.
  - in_ch=2 → no out_valid.
- Reset mid-stream: assert rst asynchronously between edges after 3 ch0 samples → outputs 0 at once. After release, ch0 0x0100 → 0x0040, out_full=0.

Source files
------------

// File: rtl/sma_multichannel.sv
// Multi-channel simple moving average: per-channel circular window, running sum and fill count.
// Emits one rounded average (round half up) per accepted sample, one cycle after the sample.
module sma_multichannel #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N      = 8,
    parameter int unsigned CH     = 4,
    parameter int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_full
);

    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned SUM_W = DATA_W + LOG2N;
    localparam int unsigned CNT_W = LOG2N + 1;

    logic [DATA_W-1:0] window [CH][N];
    logic [SUM_W-1:0]  sum    [CH];
    logic [LOG2N-1:0]  idx    [CH];
    logic [CNT_W-1:0]  cnt    [CH];

    logic              accept;
    logic              hit_clr;
    logic [SUM_W-1:0]  sel_sum;
    logic [DATA_W-1:0] sel_slot;
    logic [LOG2N-1:0]  sel_idx;
    logic [CNT_W-1:0]  sel_cnt;
    logic [SUM_W-1:0]  new_sum;
    logic [SUM_W-1:0]  rounded;
    logic [DATA_W-1:0] result;
    logic [LOG2N-1:0]  new_idx;
    logic [CNT_W-1:0]  new_cnt;

    always_comb begin
        accept   = in_valid && ({1'b0, in_ch} < (CH_W + 1)'(CH));
        hit_clr  = clr && (clr_ch == in_ch);
        sel_sum  = '0;
        sel_slot = '0;
        sel_idx  = '0;
        sel_cnt  = '0;
        for (int i = 0; i < CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                sel_sum  = sum[i];
                sel_slot = window[i][idx[i]];
                sel_idx  = idx[i];
                sel_cnt  = cnt[i];
            end
        end
        // A same-cycle clear on this channel means the sample sees an empty window.
        if (hit_clr) begin
            sel_sum  = '0;
            sel_slot = '0;
            sel_idx  = '0;
            sel_cnt  = '0;
        end
        // Exact: the evicted slot is always a component of the running sum.
        new_sum = sel_sum - SUM_W'(sel_slot) + SUM_W'(in_data);
        rounded = new_sum + SUM_W'(N / 2);
        result  = DATA_W'(rounded >> LOG2N);
        new_idx = sel_idx + LOG2N'(1);
        new_cnt = (sel_cnt == CNT_W'(N)) ? sel_cnt : sel_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < N; j++) window[c][j] <= '0;
                sum[c] <= '0;
                idx[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (clr && clr_ch == CH_W'(c)) begin
                    for (int j = 0; j < N; j++) window[c][j] <= '0;
                    sum[c] <= '0;
                    idx[c] <= '0;
                    cnt[c] <= '0;
                end
                // Later assignment wins, so a colliding sample lands on the cleared window.
                if (accept && in_ch == CH_W'(c)) begin
                    window[c][sel_idx] <= in_data;
                    sum[c] <= new_sum;
                    idx[c] <= new_idx;
                    cnt[c] <= new_cnt;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_full  <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_ch   <= in_ch;
                out_data <= result;
                out_full <= (new_cnt == CNT_W'(N));
            end
        end
    end

endmodule

// File: tb/tb_sma_multichannel.sv
// Directed bench for sma_multichannel (DATA_W=16, N=4, CH=2) with hand-computed expectations.
module tb_sma_multichannel;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 4;
    localparam int unsigned CH     = 2;
    // Widened tag so an out-of-range channel number can be presented.
    localparam int unsigned CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [CH_W-1:0]   in_ch = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              clr = 1'b0;
    logic [CH_W-1:0]   clr_ch = '0;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_full;

    int n_checks = 0;
    int n_errors = 0;

    sma_multichannel #(
        .DATA_W (DATA_W),
        .N      (N),
        .CH     (CH),
        .CH_W   (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .clr       (clr),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_full  (out_full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input int ch, input int d, input int exp,
                        input bit full);
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(d);
        tick();
        check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, ".ch"},    32'(out_ch),    32'(ch));
        check_eq({tag, ".data"},  32'(out_data),  32'(exp));
        check_eq({tag, ".full"},  32'(out_full),  32'(full));
        in_valid = 1'b0;
    endtask

    task automatic do_clr(input string tag, input int ch);
        clr    = 1'b1;
        clr_ch = CH_W'(ch);
        tick();
        check_eq({tag, ".novalid"}, 32'(out_valid), 32'd0);
        clr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst.valid", 32'(out_valid), 32'd0);
        check_eq("rst.data",  32'(out_data),  32'd0);
        check_eq("rst.ch",    32'(out_ch),    32'd0);
        check_eq("rst.full",  32'(out_full),  32'd0);
        rst = 1'b0;

        // Fill
        send("fill0", 0, 'h0100, 'h0040, 1'b0);
        send("fill1", 0, 'h0100, 'h0080, 1'b0);
        send("fill2", 0, 'h0100, 'h00C0, 1'b0);
        send("fill3", 0, 'h0100, 'h0100, 1'b1);
        // Wrap
        send("wrap0", 0, 'h0200, 'h0140, 1'b1);
        send("wrap1", 0, 'h0200, 'h0180, 1'b1);
        send("wrap2", 0, 'h0200, 'h01C0, 1'b1);
        send("wrap3", 0, 'h0200, 'h0200, 1'b1);
        tick();
        check_eq("idle.valid", 32'(out_valid), 32'd0);
        check_eq("idle.hold",  32'(out_data),  32'h0200);
        check_eq("idle.full",  32'(out_full),  32'd1);

        // Interleave, ch0 starts from an empty window
        do_clr("clr0a", 0);
        for (int k = 1; k <= 4; k++) begin
            send("ilv0", 0, 'h0400, 'h0100 * k, k == 4);
            send("ilv1", 1, 'h0010, 'h0004 * k, k == 4);
        end

        // Rounding
        do_clr("clr0b", 0);
        send("rnd0", 0, 1, 0, 1'b0);
        send("rnd1", 0, 1, 1, 1'b0);

        // Extremes
        do_clr("clr0c", 0);
        send("max0", 0, 'hFFFF, 'h4000, 1'b0);
        send("max1", 0, 'hFFFF, 'h8000, 1'b0);
        send("max2", 0, 'hFFFF, 'hBFFF, 1'b0);
        send("max3", 0, 'hFFFF, 'hFFFF, 1'b1);

        // Clear a full ch1 alone, then restart it
        do_clr("clr1", 1);
        send("clr1s", 1, 'h0008, 'h0002, 1'b0);

        // Clear and sample on the same channel
        clr    = 1'b1;
        clr_ch = 0;
        send("coll", 0, 'h0100, 'h0040, 1'b0);
        // Clear ch1 while sampling ch0
        clr_ch = 1;
        send("indep0", 0, 'h0100, 'h0080, 1'b0);
        clr = 1'b0;
        send("indep1", 1, 'h0008, 'h0002, 1'b0);

        // Out-of-range channel is dropped with no state change
        in_valid = 1'b1;
        in_ch    = 2;
        in_data  = 'h7777;
        tick();
        check_eq("badch.valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        send("badch.after", 0, 'h0100, 'h00C0, 1'b0);

        // Asynchronous reset mid-stream
        do_clr("clr0d", 0);
        send("pre0", 0, 'h0100, 'h0040, 1'b0);
        send("pre1", 0, 'h0100, 'h0080, 1'b0);
        send("pre2", 0, 'h0100, 'h00C0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.valid", 32'(out_valid), 32'd0);
        check_eq("arst.data",  32'(out_data),  32'd0);
        check_eq("arst.full",  32'(out_full),  32'd0);
        tick();
        rst = 1'b0;
        send("post0", 0, 'h0100, 'h0040, 1'b0);
        send("post1", 1, 'h0010, 'h0004, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
